// File: rtl/rh_dma_ctl.sv
// rtl/rh_dma_ctl.sv - RH11 DMA transfer sequencer between the RH11 register file and the KS10 bus
//
// Moves one word per bus cycle between the device FIFO and KS10 memory at the
// live rhBA address, pulsing the BA/WC increments after every word, and stops
// after the word whose count is 16'hFFFF. Optional feature macro:
// RHDMA_NXMTIMEOUT_EN adds a bus-acknowledge timeout of NXMTIME clocks that
// sets the sticky rhNXM flag; without it a request waits forever and rhNXM is 0.
//
// Ports:
//   clk, rst        clock, asynchronous active-high reset
//   rhCLR           synchronous controller clear, highest priority
//   rhGO            one-cycle start pulse, honoured only when idle
//   rhDIR           1 = memory to device (bus read), 0 = device to memory (bus write)
//   rhWC, rhBA      live word count and bus address from the register file
//   fifoRDY         FIFO has a word / has space
//   devACKI         bus acknowledge
//   devREQO         bus request
//   devWRO          bus write qualifier, valid with devREQO
//   devADDRO        bus address, valid with devREQO
//   fifoSTB         one-cycle FIFO push/pop strobe
//   rhINCBA, rhINCWC one-cycle address / count increment pulses
//   rhRDY           controller idle
//   rhDONE          one-cycle transfer-complete pulse
//   rhNXM           sticky non-existent-memory error
module rh_dma_ctl #(
  parameter int NXMTIME = 64
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rhCLR,
  input  logic        rhGO,
  input  logic        rhDIR,
  input  logic [15:0] rhWC,
  input  logic [17:0] rhBA,
  input  logic        fifoRDY,
  input  logic        devACKI,
  output logic        devREQO,
  output logic        devWRO,
  output logic [17:0] devADDRO,
  output logic        fifoSTB,
  output logic        rhINCBA,
  output logic        rhINCWC,
  output logic        rhRDY,
  output logic        rhDONE,
  output logic        rhNXM
);

  typedef enum logic [2:0] {
    IDLE,
    WAIT,
    REQ,
    INC,
    DONE
  } state_t;

  state_t state;
  logic   nxmHit;   // request has reached its last allowed clock

`ifdef RHDMA_NXMTIMEOUT_EN
  localparam int CntW = (NXMTIME > 1) ? $clog2(NXMTIME) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(NXMTIME - 1);

  logic [CntW-1:0] nxmCnt;

  // Counts clocks spent in REQ; held at zero elsewhere so every request starts fresh.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      nxmCnt <= '0;
    end else if (state != REQ) begin
      nxmCnt <= '0;
    end else begin
      nxmCnt <= nxmCnt + CntW'(1);
    end
  end

  assign nxmHit = (state == REQ) && (nxmCnt == CntLast);

  // An acknowledge arriving on the timeout clock still completes the word.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rhNXM <= 1'b0;
    end else if (rhCLR) begin
      rhNXM <= 1'b0;
    end else if (state == IDLE && rhGO) begin
      rhNXM <= 1'b0;
    end else if (nxmHit && !devACKI) begin
      rhNXM <= 1'b1;
    end
  end
`else
  logic unusedNxmTime;
  assign unusedNxmTime = (NXMTIME != 0);
  assign nxmHit        = 1'b0;
  assign rhNXM         = 1'b0;
`endif

  // Outputs are registered: each transition loads the values of the state being entered.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      rhRDY    <= 1'b1;
      devREQO  <= 1'b0;
      devWRO   <= 1'b0;
      devADDRO <= '0;
      fifoSTB  <= 1'b0;
      rhINCBA  <= 1'b0;
      rhINCWC  <= 1'b0;
      rhDONE   <= 1'b0;
    end else begin
      fifoSTB <= 1'b0;
      rhINCBA <= 1'b0;
      rhINCWC <= 1'b0;
      rhDONE  <= 1'b0;
      if (rhCLR) begin
        state    <= IDLE;
        rhRDY    <= 1'b1;
        devREQO  <= 1'b0;
        devWRO   <= 1'b0;
        devADDRO <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rhGO) begin
              state <= WAIT;
              rhRDY <= 1'b0;
            end
          end
          WAIT: begin
            // rhBA already reflects the previous word's increment here.
            if (fifoRDY) begin
              state    <= REQ;
              devREQO  <= 1'b1;
              devWRO   <= !rhDIR;
              devADDRO <= rhBA;
            end
          end
          REQ: begin
            if (devACKI) begin
              state    <= INC;
              devREQO  <= 1'b0;
              devWRO   <= 1'b0;
              devADDRO <= '0;
              fifoSTB  <= 1'b1;
              rhINCBA  <= 1'b1;
              rhINCWC  <= 1'b1;
            end else if (nxmHit) begin
              state    <= DONE;
              devREQO  <= 1'b0;
              devWRO   <= 1'b0;
              devADDRO <= '0;
              rhDONE   <= 1'b1;
            end else begin
              devWRO   <= !rhDIR;
              devADDRO <= rhBA;
            end
          end
          INC: begin
            // rhWC still holds the pre-increment count during this cycle.
            if (rhWC == 16'hFFFF) begin
              state  <= DONE;
              rhDONE <= 1'b1;
            end else begin
              state <= WAIT;
            end
          end
          DONE: begin
            state <= IDLE;
            rhRDY <= 1'b1;
          end
          default: begin
            state <= IDLE;
            rhRDY <= 1'b1;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_rh_dma_ctl.sv
// tb/tb_rh_dma_ctl.sv - scoreboard bench for rh_dma_ctl with a BA/WC register model
module tb_rh_dma_ctl;

  logic        clk = 1'b0;
  logic        rst;
  logic        rhCLR, rhGO, rhDIR;
  logic [15:0] rhWC;
  logic [17:0] rhBA;
  logic        fifoRDY, devACKI;
  logic        devREQO, devWRO, fifoSTB, rhINCBA, rhINCWC, rhRDY, rhDONE, rhNXM;
  logic [17:0] devADDRO;

  rh_dma_ctl #(.NXMTIME(8)) dut (
    .clk(clk), .rst(rst), .rhCLR(rhCLR), .rhGO(rhGO), .rhDIR(rhDIR),
    .rhWC(rhWC), .rhBA(rhBA), .fifoRDY(fifoRDY), .devACKI(devACKI),
    .devREQO(devREQO), .devWRO(devWRO), .devADDRO(devADDRO),
    .fifoSTB(fifoSTB), .rhINCBA(rhINCBA), .rhINCWC(rhINCWC),
    .rhRDY(rhRDY), .rhDONE(rhDONE), .rhNXM(rhNXM)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // BA/WC register model: +2 per rhINCBA, +1 per rhINCWC, loadable by the stimulus.
  logic [17:0] envBA = '0, ldBA = '0;
  logic [15:0] envWC = '0, ldWC = '0;
  logic        ldReq = 1'b0;
  always @(posedge clk) begin
    if (ldReq) begin
      envBA <= ldBA;
      envWC <= ldWC;
    end else begin
      if (rhINCBA) envBA <= envBA + 18'd2;
      if (rhINCWC) envWC <= envWC + 16'd1;
    end
  end
  assign rhBA = envBA;
  assign rhWC = envWC;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard
  typedef struct packed {
    logic [17:0] addr;
    logic        wr;
  } exp_t;
  exp_t expQ[$];
  int   expWords = 0, expLat = -1, expReqCyc = -1;
  logic expNxm = 1'b0;
  int   hs = 0, strobes = 0, reqCyc = 0, goCyc = 0, doneCnt = 0;
  bit   rdyNext = 0;

  initial begin
    forever begin
      @(negedge clk);
      if (rdyNext) begin
        check("rdy_after_done", rhRDY, 1);
        rdyNext = 0;
      end
      if (!rst && rhGO && rhRDY && !rhCLR) begin
        hs = 0; strobes = 0; reqCyc = 0; goCyc = cyc;
      end
      if (devREQO) begin
        reqCyc++;
        if (expQ.size() == 0) begin
          check("req_unexpected", 1, 0);
        end else begin
          check("req_addr", devADDRO, expQ[0].addr);
          check("req_wr", devWRO, expQ[0].wr);
          if (devACKI && !rhCLR) begin
            void'(expQ.pop_front());
            hs++;
          end
        end
      end else begin
        check("idle_addr", devADDRO, 0);
        check("idle_wr", devWRO, 0);
      end
      if (fifoSTB || rhINCBA || rhINCWC) begin
        check("strobe_agree", {fifoSTB, rhINCBA, rhINCWC}, 3'b111);
        check("strobe_noreq", devREQO, 0);
        check("strobe_follows_ack", strobes + 1, hs);
        strobes++;
      end
      if (rhDONE) begin
        check("done_words", strobes, expWords);
        check("done_nxm", rhNXM, expNxm);
        if (!expNxm) check("done_qempty", expQ.size(), 0);
        if (expLat >= 0) check("done_latency", cyc - goCyc, expLat);
        if (expReqCyc >= 0) check("req_cycles", reqCyc, expReqCyc);
        rdyNext = 1;
        doneCnt++;
      end
    end
  end

  // Bus/FIFO responder
  bit fifoRnd = 0, ackTie = 0, ackNever = 0, ackInWait = 0, manual = 0;
  int ackDelay = 0, stallWord = -1, ackStall = 0, fifoStall = 0, fifoLow = 0, reqAge = 0;

  initial begin
    fifoRDY = 1'b0;
    devACKI = 1'b0;
    forever begin
      @(posedge clk);
      #2;
      if (devREQO) reqAge++; else reqAge = 0;
      if (rhINCWC && hs == stallWord) fifoLow = fifoStall;
      if (fifoLow > 0) begin
        fifoRDY = 1'b0;
        fifoLow--;
      end else begin
        fifoRDY = fifoRnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      if (!manual) begin
        if (ackNever) devACKI = 1'b0;
        else if (ackTie) devACKI = 1'b1;
        else if (!devREQO) devACKI = ackInWait ? 1'($urandom_range(0, 1)) : 1'b0;
        else devACKI = (reqAge > ((hs == stallWord) ? ackStall : ackDelay));
      end
    end
  end

  task automatic loadAndGo(input logic [17:0] ba, input logic [15:0] wc, input logic dir,
                           input bit nxm, input int lat, input int reqc);
    int   n;
    exp_t e;
    n = (wc == 16'd0) ? 65536 : 65536 - int'(wc);
    ldBA = ba; ldWC = wc; ldReq = 1'b1; rhDIR = dir;
    @(posedge clk); #2;
    ldReq = 1'b0;
    for (int i = 0; i < n; i++) begin
      e.addr = ba + 18'(2 * i);
      e.wr   = !dir;
      expQ.push_back(e);
    end
    expWords = nxm ? 0 : n;
    expNxm = nxm; expLat = lat; expReqCyc = reqc;
    rhGO = 1'b1;
    @(posedge clk); #2;
    rhGO = 1'b0;
    check("busy_after_go", rhRDY, 0);
    check("nxm_clear_on_go", rhNXM, 0);
  endtask

  task automatic waitDone(input int d0, input bit busyGo);
    int w = 0;
    while (doneCnt == d0 && w < 400) begin
      if (busyGo && !rhRDY && $urandom_range(0, 3) == 0) rhGO = 1'b1;
      @(posedge clk); #2;
      rhGO = 1'b0;
      w++;
    end
    if (doneCnt == d0) begin
      check("done_timeout", 0, 1);
      rhCLR = 1'b1;
      @(posedge clk); #2;
      rhCLR = 1'b0;
      expQ.delete();
    end
    @(posedge clk); #2;
  endtask

  task automatic runXfer(input logic [17:0] ba, input logic [15:0] wc, input logic dir,
                         input int lat, input int reqc, input bit busyGo);
    int d0;
    d0 = doneCnt;
    loadAndGo(ba, wc, dir, 1'b0, lat, reqc);
    waitDone(d0, busyGo);
  endtask

  task automatic waitReq();
    int w = 0;
    while (!devREQO && w < 50) begin
      @(posedge clk); #2;
      w++;
    end
    check("req_reached", devREQO, 1);
  endtask

  initial begin
    #900000;
    $display("FAIL watchdog actual=running required=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1);
  end

  initial begin
    int d0;
    rst = 1'b1; rhCLR = 1'b0; rhGO = 1'b0; rhDIR = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_rdy", rhRDY, 1);
    check("rst_outs", {devREQO, devWRO, devADDRO, fifoSTB, rhINCBA, rhINCWC, rhDONE, rhNXM}, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    @(negedge clk);
    check("post_rst_rdy", rhRDY, 1);
    check("post_rst_outs", {devREQO, fifoSTB, rhINCBA, rhINCWC, rhDONE, rhNXM}, 0);

    // 3-word write, FIFO and ack tied high: best-case 3 clocks per word
    @(posedge clk); #2;
    ackTie = 1;
    runXfer(18'o1000, 16'hFFFD, 1'b0, 10, 3, 0);
    check("ba_after_3", envBA, 18'o1006);
    check("wc_after_3", envWC, 16'h0000);
    ackTie = 0;

    // FIFO stall and 7-clock ack delay on word 2 (bus read)
    stallWord = 1; fifoStall = 5; ackStall = 7; ackDelay = 0;
    runXfer(18'o2000, 16'hFFFD, 1'b1, -1, 10, 0);
    stallWord = -1;

    // address wraps at 18 bits
    runXfer(18'h3FFFE, 16'hFFFE, 1'b0, -1, 2, 0);

    // abort with rhCLR and devACKI together while requesting
    ackNever = 1;
    loadAndGo(18'o4000, 16'hFFFB, 1'b0, 1'b0, -1, -1);
    waitReq();
`ifdef RHDMA_NXMTIMEOUT_EN
    repeat (3) begin
`else
    repeat (20) begin
`endif
      @(posedge clk); #2;
      check("req_hold", devREQO, 1);
      check("req_hold_nxm", rhNXM, 0);
    end
    manual = 1; rhCLR = 1'b1; devACKI = 1'b1;
    @(posedge clk); #2;
    rhCLR = 1'b0; devACKI = 1'b0;
    check("clr_rdy", rhRDY, 1);
    check("clr_outs", {devREQO, fifoSTB, rhINCBA, rhINCWC, rhDONE, rhNXM}, 0);
    @(posedge clk); #2;
    check("clr_quiet", {devREQO, fifoSTB, rhINCBA, rhINCWC, rhDONE}, 0);
    manual = 0; ackNever = 0;
    expQ.delete();
    runXfer(18'o4000, 16'hFFFE, 1'b0, -1, -1, 0);

`ifdef RHDMA_NXMTIMEOUT_EN
    // unacknowledged request times out after 8 REQ clocks with no increments
    ackNever = 1;
    d0 = doneCnt;
    loadAndGo(18'o5000, 16'hFFFE, 1'b0, 1'b1, -1, 8);
    waitDone(d0, 0);
    check("nxm_sticky", rhNXM, 1);
    check("nxm_no_ba_inc", envBA, 18'o5000);
    check("nxm_no_wc_inc", envWC, 16'hFFFE);
    expQ.delete();
    ackNever = 0;
    runXfer(18'o5000, 16'hFFFF, 1'b1, -1, -1, 0);
`endif

    // asynchronous reset in mid-transfer
    ackNever = 1;
    loadAndGo(18'o6000, 16'hFFFC, 1'b0, 1'b0, -1, -1);
    waitReq();
    @(negedge clk); #1;
    rst = 1'b1;
    #1;
    check("arst_rdy", rhRDY, 1);
    check("arst_outs", {devREQO, devADDRO, fifoSTB, rhINCBA, rhINCWC, rhDONE}, 0);
    @(posedge clk); #2;
    rst = 1'b0;
    expQ.delete();
    ackNever = 0;

    // rhGO while busy and spurious acks in WAIT are ignored
    fifoRnd = 1; ackInWait = 1; ackDelay = 1;
    runXfer(18'o7000, 16'hFFFE, 1'b0, -1, -1, 1);
    check("busy_go_wc", envWC, 16'h0000);

    // randomized transfers
    for (int t = 0; t < 20; t++) begin
      int n;
      fifoRnd = 1;
      ackDelay = $urandom_range(0, 3);
      ackInWait = 1'($urandom_range(0, 1));
      n = $urandom_range(1, 4);
      runXfer(18'($urandom), 16'(65536 - n), 1'($urandom_range(0, 1)), -1, -1,
              1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
